// File: rtl/arb_pkg.sv
// Shared types for the instruction/data memory-port arbiter.
// Holds the arbiter state encoding and the one-hot grant codes.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  function automatic logic [1:0] grant_of(input arb_state_t s);
    case (s)
      SERVE_I: return GRANT_I;
      SERVE_D: return GRANT_D;
      default: return GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational 2-way round-robin selector: returns a one-hot pick {d, i}.
// On a tie the requester that did not own the port last time wins.
module arb_rr_pick
  import arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_d,
  output logic [1:0] o_pick
);

  always_comb begin
    o_pick = GRANT_NONE;
    case (i_req)
      2'b01:   o_pick = GRANT_I;
      2'b10:   o_pick = GRANT_D;
      2'b11:   o_pick = i_last_d ? GRANT_I : GRANT_D;
      default: o_pick = GRANT_NONE;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one physical memory port between instruction fetch and load/store.
// Registered round-robin arbitration; the grant is held until mem_resp.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_read,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_byte_enable,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_byte_enable,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_resp,
  output logic [1:0]            grant,
  output logic [1:0]            o_state
);

  arb_state_t r_state;
  arb_state_t w_next_state;
  logic       r_last_d;
  logic       w_next_last_d;
  logic [1:0] r_grant;
  logic       w_d_req;
  logic [1:0] w_req;
  logic [1:0] w_pick;

  assign w_d_req = d_read | d_write;

  // While serving, only the other side may be picked: the owner's request
  // is still high on its own response cycle and must not win again.
  assign w_req = (r_state == SERVE_I) ? {w_d_req, 1'b0} :
                 (r_state == SERVE_D) ? {1'b0, i_read}  :
                                        {w_d_req, i_read};

  arb_rr_pick u_pick (
    .i_req    (w_req),
    .i_last_d (r_last_d),
    .o_pick   (w_pick)
  );

  always_comb begin
    w_next_state  = r_state;
    w_next_last_d = r_last_d;
    case (r_state)
      IDLE: begin
        if (w_pick == GRANT_I)      w_next_state = SERVE_I;
        else if (w_pick == GRANT_D) w_next_state = SERVE_D;
      end
      SERVE_I: begin
        if (mem_resp) begin
          w_next_last_d = 1'b0;
          w_next_state  = (w_pick == GRANT_D) ? SERVE_D : IDLE;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          w_next_last_d = 1'b1;
          w_next_state  = (w_pick == GRANT_I) ? SERVE_I : IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_last_d <= 1'b1;
      r_grant  <= GRANT_NONE;
    end else begin
      r_state  <= w_next_state;
      r_last_d <= w_next_last_d;
      r_grant  <= grant_of(w_next_state);
    end
  end

  assign grant   = r_grant;
  assign o_state = r_state;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // A data request with both read and write set is treated as a write.
  always_comb begin
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_wdata       = '0;
    mem_byte_enable = '0;
    i_resp          = 1'b0;
    d_resp          = 1'b0;
    case (r_state)
      SERVE_I: begin
        mem_read        = i_read;
        mem_address     = i_addr;
        mem_byte_enable = '1;
        i_resp          = mem_resp;
      end
      SERVE_D: begin
        mem_write       = d_write;
        mem_read        = d_read & ~d_write;
        mem_address     = d_addr;
        mem_wdata       = d_wdata;
        mem_byte_enable = d_byte_enable;
        d_resp          = mem_resp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a latency-programmable memory model
// answers the physical port while a scoreboard checks response order/content.
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int SB_W = 1 + AW + DW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          i_read = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [BW-1:0] d_byte_enable = '0;
  logic [DW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_byte_enable;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_resp = 1'b0;
  logic [1:0]    grant;
  logic [1:0]    dbg_state;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_read          (i_read),
    .i_addr          (i_addr),
    .i_rdata         (i_rdata),
    .i_resp          (i_resp),
    .d_read          (d_read),
    .d_write         (d_write),
    .d_addr          (d_addr),
    .d_wdata         (d_wdata),
    .d_byte_enable   (d_byte_enable),
    .d_rdata         (d_rdata),
    .d_resp          (d_resp),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .grant           (grant),
    .o_state         (dbg_state)
  );

  int n_pass = 0;
  int n_total = 0;
  int n_proto_viol = 0;
  logic [SB_W-1:0] exp_q[$];

  // memory model
  int lat_lo = 3;
  int lat_hi = 3;
  int cur_lat = 0;
  int mcnt = 0;
  logic [AW-1:0] st_addr = '0;
  logic [DW-1:0] st_data = '0;
  logic [BW-1:0] st_be = '0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 32'h60) return 32'h0000_0013;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_resp = 1'b0;
      mem_rdata = '0;
      mcnt = 0;
    end else begin
      #1;
      if (mem_resp) begin
        mem_resp = 1'b0;
        mem_rdata = '0;
        mcnt = 0;
      end else if (mem_read || mem_write) begin
        if (mcnt == 0) cur_lat = $urandom_range(lat_hi, lat_lo);
        mcnt++;
        if (mcnt >= cur_lat) begin
          mem_resp = 1'b1;
          mem_rdata = mem_word(mem_address);
          if (mem_write) begin
            st_addr = mem_address;
            st_data = mem_wdata;
            st_be = mem_byte_enable;
          end
        end
      end
    end
  end

  // protocol monitor: simultaneous load and store request
  always @(negedge clk) begin
    if (rst_n && d_read && d_write) n_proto_viol++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_byte_enable = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_total++;
    if ({grant, dbg_state} !== 4'b0) $display("FAIL reset_grant: got %b want 0000", {grant, dbg_state});
    else n_pass++;
    n_total++;
    if ({mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, i_resp, d_resp} !== '0)
      $display("FAIL reset_outputs: got r=%b w=%b a=%h ir=%b dr=%b want all 0",
               mem_read, mem_write, mem_address, i_resp, d_resp);
    else n_pass++;
    i_read = 1'b1;
    @(negedge clk);
    n_total++;
    if ({grant, mem_read} !== 3'b000) $display("FAIL reset_hold: got %b want 000", {grant, mem_read});
    else n_pass++;
    i_read = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lone_fetch;
    logic [SB_W-1:0] obs, e;
    int n_i, n_d;
    n_i = 0; n_d = 0;
    lat_lo = 3; lat_hi = 3;
    i_read = 1'b1; i_addr = 32'h60;
    exp_q.push_back({1'b0, 32'h0000_0060, 32'h0000_0013});
    #1;
    n_total++;
    if (mem_read !== 1'b0) $display("FAIL fetch_early: got mem_read=%b want 0", mem_read);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({mem_read, mem_write, grant, mem_address, mem_byte_enable} !== {1'b1, 1'b0, 2'b01, 32'h60, 4'hF})
      $display("FAIL fetch_issue: got r=%b w=%b g=%b a=%h be=%h want 1 0 01 00000060 f",
               mem_read, mem_write, grant, mem_address, mem_byte_enable);
    else n_pass++;
    repeat (12) begin
      if (d_resp) n_d++;
      if (i_resp) begin
        n_i++;
        obs = {1'b0, mem_address, i_rdata};
        n_total++;
        if (exp_q.size() == 0) $display("FAIL fetch_sb: got %h want none", obs);
        else begin
          e = exp_q.pop_front();
          if (obs !== e) $display("FAIL fetch_sb: got %h want %h", obs, e);
          else n_pass++;
        end
        i_read = 1'b0;
      end
      @(negedge clk);
    end
    n_total++;
    if (n_i != 1 || n_d != 0) $display("FAIL fetch_resp_count: got i=%0d d=%0d want i=1 d=0", n_i, n_d);
    else n_pass++;
    n_total++;
    if (grant !== 2'b00 || exp_q.size() != 0)
      $display("FAIL fetch_idle: got grant=%b pending=%0d want 00 0", grant, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_lone_store;
    logic [SB_W-1:0] obs, e;
    int n_i, n_d, n_rd;
    n_i = 0; n_d = 0; n_rd = 0;
    lat_lo = 2; lat_hi = 4;
    d_write = 1'b1; d_addr = 32'h104; d_wdata = 32'hDEAD_BEEF; d_byte_enable = 4'b0100;
    exp_q.push_back({1'b1, 32'h0000_0104, 32'hDEAD_BEEF});
    @(negedge clk);
    n_total++;
    if ({mem_write, mem_read, grant, mem_address, mem_wdata, mem_byte_enable} !==
        {1'b1, 1'b0, 2'b10, 32'h104, 32'hDEAD_BEEF, 4'b0100})
      $display("FAIL store_issue: got w=%b r=%b g=%b a=%h d=%h be=%b want 1 0 10 00000104 deadbeef 0100",
               mem_write, mem_read, grant, mem_address, mem_wdata, mem_byte_enable);
    else n_pass++;
    repeat (12) begin
      if (mem_read) n_rd++;
      if (i_resp) n_i++;
      if (d_resp) begin
        n_d++;
        obs = {1'b1, mem_address, mem_wdata};
        n_total++;
        if (exp_q.size() == 0) $display("FAIL store_sb: got %h want none", obs);
        else begin
          e = exp_q.pop_front();
          if (obs !== e) $display("FAIL store_sb: got %h want %h", obs, e);
          else n_pass++;
        end
        d_write = 1'b0;
      end
      @(negedge clk);
    end
    n_total++;
    if (n_d != 1 || n_i != 0 || n_rd != 0)
      $display("FAIL store_resp_count: got d=%0d i=%0d rd=%0d want 1 0 0", n_d, n_i, n_rd);
    else n_pass++;
    n_total++;
    if ({st_addr, st_data, st_be} !== {32'h104, 32'hDEAD_BEEF, 4'b0100})
      $display("FAIL store_mem: got a=%h d=%h be=%b want 00000104 deadbeef 0100", st_addr, st_data, st_be);
    else n_pass++;
  endtask

  task automatic test_tie;
    logic [SB_W-1:0] obs, e;
    logic chk_next;
    chk_next = 1'b0;
    do_reset();
    lat_lo = 1; lat_hi = 3;
    i_read = 1'b1; i_addr = 32'h200;
    d_read = 1'b1; d_addr = 32'h300;
    exp_q.push_back({1'b0, 32'h200, mem_word(32'h200)});
    exp_q.push_back({1'b1, 32'h300, mem_word(32'h300)});
    @(negedge clk);
    n_total++;
    if (grant !== 2'b01) $display("FAIL tie_first: got grant=%b want 01", grant);
    else n_pass++;
    repeat (20) begin
      if (chk_next) begin
        chk_next = 1'b0;
        n_total++;
        if ({grant, mem_read, mem_address} !== {2'b10, 1'b1, 32'h300})
          $display("FAIL tie_switch: got g=%b r=%b a=%h want 10 1 00000300", grant, mem_read, mem_address);
        else n_pass++;
      end
      if (i_resp || d_resp) begin
        obs = {d_resp, mem_address, d_resp ? d_rdata : i_rdata};
        n_total++;
        if (exp_q.size() == 0) $display("FAIL tie_sb: got %h want none", obs);
        else begin
          e = exp_q.pop_front();
          if (obs !== e) $display("FAIL tie_sb: got %h want %h", obs, e);
          else n_pass++;
        end
        if (i_resp) begin i_read = 1'b0; chk_next = 1'b1; end
        else d_read = 1'b0;
      end
      @(negedge clk);
    end
    n_total++;
    if (exp_q.size() != 0) $display("FAIL tie_drain: got pending=%0d want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_alternation;
    logic [SB_W-1:0] obs, e;
    logic prev_valid, prev_side, side;
    int ni, nd;
    ni = 0; nd = 0; prev_valid = 1'b0; prev_side = 1'b0;
    do_reset();
    lat_lo = 1; lat_hi = 4;
    i_read = 1'b1; i_addr = 32'h1000;
    d_read = 1'b1; d_addr = 32'h2000;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({1'b0, 32'h1000 + 32'(4 * k), mem_word(32'h1000 + 32'(4 * k))});
      exp_q.push_back({1'b1, 32'h2000 + 32'(4 * k), mem_word(32'h2000 + 32'(4 * k))});
    end
    repeat (80) begin
      if (i_resp || d_resp) begin
        side = d_resp;
        obs = {side, mem_address, side ? d_rdata : i_rdata};
        n_total++;
        if (exp_q.size() == 0) $display("FAIL alt_sb: got %h want none", obs);
        else begin
          e = exp_q.pop_front();
          if (obs !== e) $display("FAIL alt_sb: got %h want %h", obs, e);
          else n_pass++;
        end
        n_total++;
        if (prev_valid && prev_side === side) $display("FAIL alt_repeat: got side %b twice want alternate", side);
        else n_pass++;
        prev_valid = 1'b1; prev_side = side;
        if (side) begin
          nd++;
          if (nd < 3) d_addr = 32'h2000 + 32'(4 * nd);
          else d_read = 1'b0;
        end else begin
          ni++;
          if (ni < 3) i_addr = 32'h1000 + 32'(4 * ni);
          else i_read = 1'b0;
        end
      end
      @(negedge clk);
    end
    n_total++;
    if (ni != 3 || nd != 3 || exp_q.size() != 0)
      $display("FAIL alt_count: got i=%0d d=%0d pending=%0d want 3 3 0", ni, nd, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [SB_W-1:0] obs, e;
    logic chk_idle;
    int n;
    n = 0; chk_idle = 1'b0;
    do_reset();
    lat_lo = 1; lat_hi = 2;
    i_read = 1'b1; i_addr = 32'h40;
    for (int k = 0; k < 3; k++)
      exp_q.push_back({1'b0, 32'h40 + 32'(4 * k), mem_word(32'h40 + 32'(4 * k))});
    repeat (40) begin
      if (chk_idle) begin
        chk_idle = 1'b0;
        n_total++;
        if (grant !== 2'b00) $display("FAIL b2b_bubble: got grant=%b want 00", grant);
        else n_pass++;
      end
      if (i_resp) begin
        obs = {1'b0, mem_address, i_rdata};
        n_total++;
        if (exp_q.size() == 0) $display("FAIL b2b_sb: got %h want none", obs);
        else begin
          e = exp_q.pop_front();
          if (obs !== e) $display("FAIL b2b_sb: got %h want %h", obs, e);
          else n_pass++;
        end
        n++;
        if (n < 3) i_addr = 32'h40 + 32'(4 * n);
        else i_read = 1'b0;
        chk_idle = 1'b1;
      end
      @(negedge clk);
    end
    n_total++;
    if (n != 3) $display("FAIL b2b_count: got %0d want 3", n);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    do_reset();
    lat_lo = 10; lat_hi = 10;
    d_write = 1'b1; d_addr = 32'h400; d_wdata = 32'hCAFE_F00D; d_byte_enable = 4'hF;
    repeat (2) @(negedge clk);
    n_total++;
    if ({mem_write, grant} !== 3'b110) $display("FAIL rstmid_busy: got w=%b g=%b want 1 10", mem_write, grant);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({mem_write, mem_read, grant, i_resp, d_resp, mem_address} !== '0)
      $display("FAIL rstmid_async: got w=%b r=%b g=%b ir=%b dr=%b a=%h want all 0",
               mem_write, mem_read, grant, i_resp, d_resp, mem_address);
    else n_pass++;
    i_read = 1'b1; i_addr = 32'h80;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if ({grant, mem_address} !== {2'b01, 32'h80})
      $display("FAIL rstmid_tie: got g=%b a=%h want 01 00000080", grant, mem_address);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_illegal;
    logic [SB_W-1:0] obs, e;
    int v0;
    do_reset();
    lat_lo = 2; lat_hi = 2;
    v0 = n_proto_viol;
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h500; d_wdata = 32'h1234_5678; d_byte_enable = 4'hF;
    exp_q.push_back({1'b1, 32'h500, 32'h1234_5678});
    @(negedge clk);
    #1;
    n_total++;
    if ({mem_write, mem_read, grant} !== 4'b1010)
      $display("FAIL illegal_mux: got w=%b r=%b g=%b want 1 0 10", mem_write, mem_read, grant);
    else n_pass++;
    n_total++;
    if (n_proto_viol <= v0) $display("FAIL illegal_flag: got %0d violations want more than %0d", n_proto_viol, v0);
    else n_pass++;
    @(negedge clk);
    repeat (12) begin
      if (d_resp) begin
        obs = {1'b1, mem_address, mem_wdata};
        n_total++;
        if (exp_q.size() == 0) $display("FAIL illegal_sb: got %h want none", obs);
        else begin
          e = exp_q.pop_front();
          if (obs !== e) $display("FAIL illegal_sb: got %h want %h", obs, e);
          else n_pass++;
        end
        d_read = 1'b0; d_write = 1'b0;
      end
      @(negedge clk);
    end
    n_total++;
    if (exp_q.size() != 0) $display("FAIL illegal_drain: got pending=%0d want 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_lone_store();
    test_tie();
    test_alternation();
    test_back_to_back();
    test_reset_mid();
    test_illegal();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single physical memory port between the instruction-fetch path and the load/store data path of the multicycle RV32I core. It sits between the core's requesters and the memory, and uses the same level-held mem_read/mem_write, single-cycle mem_resp handshake on both sides. Arbitration is registered, grants are held until the physical response, and simultaneous requests are resolved round-robin.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_read  in  1  instruction read request, held until i_resp
- i_addr  in  ADDR_W  instruction address
- i_rdata  out  DATA_W  instruction read data
- i_resp  out  1  instruction transaction complete, one-cycle pulse
- d_read / d_write  in  1  data read/write request, held until d_resp
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_byte_enable  in  DATA_W/8  store byte mask
- d_rdata  out  DATA_W  load data
- d_resp  out  1  data transaction complete, one-cycle pulse
- mem_read / mem_write  out  1  physical request
- mem_address  out  ADDR_W  physical address
- mem_wdata  out  DATA_W  physical store data
- mem_byte_enable  out  DATA_W/8  physical byte mask
- mem_rdata  in  DATA_W  physical read data
- mem_resp  in  1  physical completion
- grant  out  2  {d, i} one-hot owner; 2'b00 when idle

## Operation
- States: IDLE, SERVE_I, SERVE_D. last_d (1 bit) records the most recent owner.
- IDLE:
  - only i_read → SERVE_I
  - only d_read|d_write → SERVE_D
  - both pending → SERVE_I if last_d=1, else SERVE_D
  - neither pending → stay IDLE
- SERVE_X:
  - Forward requester X's read/write/address/wdata/byte_enable to the mem_* outputs combinationally.
  - Route mem_resp to X_resp only; the other requester's resp stays 0.
  - i_rdata and d_rdata both equal mem_rdata at all times.
  - On mem_resp: set last_d according to X. If the other requester is pending, go directly to SERVE_other; otherwise go to IDLE.
  - Never re-grant X on its own resp cycle, because X's request is still high in that cycle.
- Outside a SERVE state, mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable and both resp outputs are 0.
- Instruction grants always drive mem_write=0 and mem_byte_enable=4'b1111.
- If d_read and d_write are both asserted, mem_write wins and mem_read=0. The bench flags this as a protocol violation.
- A requester that drops its request mid-grant without a resp is a protocol violation. The grant is kept until mem_resp regardless.
- Reset (asynchronous, any time, including mid-transaction):
  - state=IDLE, last_d=1, so the instruction side wins the first tie
  - all outputs 0
  - any in-flight physical transaction is abandoned

## Timing
- Arbitration latency is one cycle: a request first seen in IDLE at edge n gives mem_read/mem_write high from cycle n+1.
- Response latency adds zero cycles: X_resp=mem_resp in the same cycle.
- Switching owners: when the other requester is pending at mem_resp, the new owner's request is on the mem_* outputs in the very next cycle, with no IDLE bubble.
- Inputs sampled for arbitration: i_read, d_read, d_write at the rising edge. No other inputs are registered.
- grant is registered and matches the state (SERVE_I=01, SERVE_D=10, IDLE=00).

## Structure
- Shared package (rv32i_types or an arbiter package) holds:
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D}
  - localparams GRANT_I=2'b01 and GRANT_D=2'b10
- One always_ff holds state and last_d. One always_comb holds next-state logic and one holds the output mux.
- Optional sub-module: arb_rr_pick, a combinational 2-way round-robin selector taking req[1:0] and last_d and returning a one-hot pick. It is reusable for a later cache/memory arbiter.

## Test plan
- Lone fetch: i_read=1, i_addr=0x60; memory responds 3 cycles later with 0x00000013 → mem_read high from cycle+1; i_resp pulses once with i_rdata=0x13; d_resp stays 0; state returns to IDLE.
- Lone store: d_write=1, d_addr=0x104, d_wdata=0xDEADBEEF, d_byte_enable=4'b0100 → mem_write=1 with identical address/data/mask; d_resp pulses once; mem_read stays 0.
- Tie after reset: i_read and d_read both asserted in the same cycle → grant=01 first; on its mem_resp the next cycle shows grant=10 and mem_address=d_addr, with no idle cycle between.
- Alternation: both requesters held continuously for 6 transactions → grant sequence I,D,I,D,I,D; no requester is served twice in a row.
- Reset mid-transaction: rst_n low while in SERVE_D with mem_write=1 → mem_write, grant and resps go to 0 immediately (asynchronously); after release, a pending tie goes to I.
- Illegal request: d_read=d_write=1 → mem_write=1, mem_read=0; the bench assertion fires.
